modbus_rx_framer: RTL

// Sequences the UART receive path ahead of ModbusToWishbone. Drains bytes from the UART RX

---
 rtl/modbus_pkg.sv | 42 ++++
 rtl/modbus_rx_framer_if.sv | 26 ++
 rtl/modbus_crc16.sv | 32 +++
 rtl/modbus_rx_framer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : modbus_pkg
// Description : Shared types and constants for the Modbus RTU receive framer:
//               FSM state encoding, CRC-16 constants, drop reason codes and a
//               one-byte CRC-16/Modbus update function.
// Revision    : 1.0  initial release
// ============================================================================
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RECV  = 3'd2,
    ST_CHECK = 3'd3,
    ST_READY = 3'd4
  } state_t;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  localparam logic [1:0] DROP_CRC   = 2'd0;
  localparam logic [1:0] DROP_SHORT = 2'd1;
  localparam logic [1:0] DROP_LONG  = 2'd2;
  localparam logic [1:0] DROP_UART  = 2'd3;

  // Shortest frame worth checking: address, function code, two CRC bytes.
  localparam int MIN_FRAME = 4;

  // Reflected CRC-16 update, all eight bit steps unrolled into one cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modbus_rx_framer_if.sv
`default_nettype none
// ============================================================================
// Interface   : modbus_rx_framer_if
// Description : UART receive handshake between the byte receiver (master)
//               and the frame sequencer (slave), plus the line-idle flag.
// Revision    : 1.0  initial release
// ============================================================================
interface modbus_rx_framer_if;
  logic [8:0] dataIn;
  logic       dataReceived;
  logic       parityError;
  logic       overflow;
  logic       silence;
  logic       receiveReq;

  modport master (
    output dataIn, dataReceived, parityError, overflow, silence,
    input  receiveReq
  );

  modport slave (
    input  dataIn, dataReceived, parityError, overflow, silence,
    output receiveReq
  );
endinterface
`default_nettype wire

// File: rtl/modbus_crc16.sv
`default_nettype none
// ============================================================================
// Module      : modbus_crc16
// Description : Running CRC-16/Modbus register. clear restarts from the init
//               value; when clear and enable coincide the byte is folded
//               into a fresh CRC, so a frame's first byte is never lost.
// Revision    : 1.0  initial release
// ============================================================================
module modbus_crc16
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // Accumulate one byte per enable, restarting from the init value on clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc16_byte(clear ? CRC_INIT : crc, data);
    end else if (clear) begin
      crc <= CRC_INIT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modbus_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : modbus_rx_framer
// Description : Pops bytes from the UART, delimits RTU frames on line
//               silence, checks CRC, length and unit address, and holds an
//               accepted frame in a local buffer until it is acknowledged.
// Revision    : 1.0  initial release
// ============================================================================
module modbus_rx_framer
  import modbus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h37,
  parameter int         MAX_FRAME  = 256,
  parameter int         LEN_W      = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  modbus_rx_framer_if.slave    uart,
  output logic                 frameValid,
  output logic [LEN_W-1:0]     frameLen,
  input  logic [7:0]           rdAddr,
  output logic [7:0]           rdData,
  input  logic                 frameAck,
  output logic                 dropPulse,
  output logic [1:0]           dropCode
);

  localparam int               IDX_W   = $clog2(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME);

  state_t           r_state;
  logic             r_armed;
  logic             r_receive_req;
  logic             r_too_long;
  logic             r_uart_err;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_buffer [MAX_FRAME];

  logic [15:0]      w_crc;
  logic [7:0]       w_byte;
  logic             w_byte_err;
  logic             w_hold;
  logic             w_pop;
  logic             w_in_frame;
  logic             w_store;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_addr_ok;
  logic             w_unused_bit;

  assign w_byte       = uart.dataIn[7:0];
  assign w_unused_bit = uart.dataIn[8];
  assign w_byte_err   = uart.parityError | uart.overflow;

  // A byte arriving with the closing silence, or during the check cycle,
  // is left pending in the UART so it opens the next frame from IDLE.
  assign w_hold = (r_state == ST_CHECK) || ((r_state == ST_RECV) && uart.silence);

  // Edge-armed pop: dataReceived must have been seen low since the last pop.
  assign w_pop = uart.dataReceived && r_armed && !r_receive_req && !w_hold;

  assign w_in_frame = (r_state == ST_IDLE) || (r_state == ST_RECV);
  assign w_store    = w_pop && ((r_state == ST_IDLE) ||
                                ((r_state == ST_RECV) && (r_len < LEN_MAX)));
  assign w_wr_idx   = (r_state == ST_IDLE) ? '0 : r_len[IDX_W-1:0];
  assign w_addr_ok  = (r_buffer[0] == SLAVE_ADDR) || (r_buffer[0] == 8'h00);

  assign uart.receiveReq = r_receive_req;
  assign rdData          = r_buffer[rdAddr[IDX_W-1:0]];

  modbus_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (r_state == ST_IDLE),
    .enable (w_pop && w_in_frame),
    .data   (w_byte),
    .crc    (w_crc)
  );

  // Frame buffer write; contents are meaningful only while frameValid is set.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_buffer[w_wr_idx] <= w_byte;
    end
  end

  // Pop handshake, frame sequencing FSM and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_HUNT;
      r_armed       <= 1'b0;
      r_receive_req <= 1'b0;
      r_too_long    <= 1'b0;
      r_uart_err    <= 1'b0;
      r_len         <= '0;
      frameValid    <= 1'b0;
      frameLen      <= '0;
      dropPulse     <= 1'b0;
      dropCode      <= 2'd0;
    end else begin
      r_receive_req <= w_pop;
      dropPulse     <= 1'b0;
      if (w_pop) begin
        r_armed <= 1'b0;
      end else if (!uart.dataReceived) begin
        r_armed <= 1'b1;
      end

      case (r_state)
        ST_HUNT: begin
          if (uart.silence) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          r_len      <= '0;
          r_too_long <= 1'b0;
          r_uart_err <= 1'b0;
          if (w_pop) begin
            r_len      <= LEN_W'(1);
            r_uart_err <= w_byte_err;
            r_state    <= ST_RECV;
          end
        end

        ST_RECV: begin
          if (uart.silence) begin
            r_state <= ST_CHECK;
          end
          if (w_pop) begin
            if (r_len >= LEN_MAX) begin
              r_too_long <= 1'b1;
            end
            if (r_len != LEN_SAT) begin
              r_len <= r_len + LEN_W'(1);
            end
            if (w_byte_err) begin
              r_uart_err <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (r_uart_err) begin
            dropPulse <= 1'b1;
            dropCode  <= DROP_UART;
          end else if (r_too_long) begin
            dropPulse <= 1'b1;
            dropCode  <= DROP_LONG;
          end else if (r_len < LEN_MIN) begin
            dropPulse <= 1'b1;
            dropCode  <= DROP_SHORT;
          end else if (w_crc != 16'h0000) begin
            dropPulse <= 1'b1;
            dropCode  <= DROP_CRC;
          end else if (w_addr_ok) begin
            frameValid <= 1'b1;
            frameLen   <= r_len;
            r_state    <= ST_READY;
          end
        end

        ST_READY: begin
          if (frameAck) begin
            frameValid <= 1'b0;
            r_state    <= uart.silence ? ST_IDLE : ST_HUNT;
          end
        end

        default: begin
          r_state <= ST_HUNT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
